// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: processes DIGIT bits per cycle over N = WIDTH/DIGIT cycles
// with a registered inter-digit carry and a Start/Busy/Done handshake.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             Mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow,
  output logic             Busy,
  output logic             Done
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("digit_serial_adder: WIDTH must be an integer multiple of DIGIT");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] opa_r;
  logic [WIDTH-1:0] opb_r;
  logic [WIDTH-1:0] res_r;
  logic             carry_r;
  logic [CNT_W-1:0] cnt_r;

  logic [DIGIT:0]   digit_sum_s;
  logic             msb_carry_in_s;
  logic [WIDTH-1:0] res_shift_s;

  // Shared digit slice; carry into the digit MSB is recovered as a ^ b ^ sum of that bit.
  always_comb begin
    digit_sum_s    = {1'b0, opa_r[DIGIT-1:0]} + {1'b0, opb_r[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry_r};
    msb_carry_in_s = opa_r[DIGIT-1] ^ opb_r[DIGIT-1] ^ digit_sum_s[DIGIT-1];
    res_shift_s    = (res_r >> DIGIT)
                   | (WIDTH'(digit_sum_s[DIGIT-1:0]) << (WIDTH - DIGIT));
  end

  // Control FSM, operand/result datapath and registered outputs.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_r  <= IDLE;
      opa_r    <= {WIDTH{1'b0}};
      opb_r    <= {WIDTH{1'b0}};
      res_r    <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      Sum      <= {WIDTH{1'b0}};
      Cout     <= 1'b0;
      Overflow <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (Start) begin
            opa_r   <= A;
            opb_r   <= B ^ {WIDTH{Mode}};
            carry_r <= Cin ^ Mode;
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= RUN;
            Busy    <= 1'b1;
          end else begin
            Busy    <= 1'b0;
          end
        end
        RUN: begin
          opa_r   <= opa_r >> DIGIT;
          opb_r   <= opb_r >> DIGIT;
          carry_r <= digit_sum_s[DIGIT];
          res_r   <= res_shift_s;
          if (cnt_r == LAST_DIGIT) begin
            Sum      <= res_shift_s;
            Cout     <= digit_sum_s[DIGIT];
            Overflow <= msb_carry_in_s ^ digit_sum_s[DIGIT];
            Done     <= 1'b1;
            Busy     <= 1'b0;
            state_r  <= IDLE;
          end else begin
            cnt_r    <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed self-checking bench: three adder instances (DIGIT = 4, 1, 16) with hand-computed results.
module tb_digit_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic        cin;
  logic [15:0] a;
  logic [15:0] b;
  logic        start4, start1, start16;

  logic [15:0] sum4, sum1, sum16;
  logic        cout4, cout1, cout16;
  logic        ovf4, ovf1, ovf16;
  logic        busy4, busy1, busy16;
  logic        done4, done1, done16;

  int n_compared = 0;
  int n_mismatch = 0;

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut4 (
    .Clk(clk), .Rst_n(rst_n), .Start(start4), .Mode(mode), .A(a), .B(b), .Cin(cin),
    .Sum(sum4), .Cout(cout4), .Overflow(ovf4), .Busy(busy4), .Done(done4));

  digit_serial_adder #(.WIDTH(16), .DIGIT(1)) dut1 (
    .Clk(clk), .Rst_n(rst_n), .Start(start1), .Mode(mode), .A(a), .B(b), .Cin(cin),
    .Sum(sum1), .Cout(cout1), .Overflow(ovf1), .Busy(busy1), .Done(done1));

  digit_serial_adder #(.WIDTH(16), .DIGIT(16)) dut16 (
    .Clk(clk), .Rst_n(rst_n), .Start(start16), .Mode(mode), .A(a), .B(b), .Cin(cin),
    .Sum(sum16), .Cout(cout16), .Overflow(ovf16), .Busy(busy16), .Done(done16));

  function automatic logic [15:0] get_sum(input int idx);
    case (idx)
      0: return sum4;
      1: return sum1;
      default: return sum16;
    endcase
  endfunction

  function automatic logic get_cout(input int idx);
    case (idx)
      0: return cout4;
      1: return cout1;
      default: return cout16;
    endcase
  endfunction

  function automatic logic get_ovf(input int idx);
    case (idx)
      0: return ovf4;
      1: return ovf1;
      default: return ovf16;
    endcase
  endfunction

  function automatic logic get_busy(input int idx);
    case (idx)
      0: return busy4;
      1: return busy1;
      default: return busy16;
    endcase
  endfunction

  function automatic logic get_done(input int idx);
    case (idx)
      0: return done4;
      1: return done1;
      default: return done16;
    endcase
  endfunction

  function automatic int digits_of(input int idx);
    case (idx)
      0: return 4;
      1: return 16;
      default: return 1;
    endcase
  endfunction

  task automatic set_start(input int idx, input logic v);
    case (idx)
      0: start4 = v;
      1: start1 = v;
      default: start16 = v;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp)
    else begin
      n_mismatch++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ticks until Done of instance idx rises, bounded; lat counts edges waited.
  task automatic wait_done(input int idx, input string tag, inout int lat);
    do begin
      tick();
      lat++;
    end while (get_done(idx) !== 1'b1 && lat < 40);
    check({tag, "_done_seen"}, {31'd0, get_done(idx)}, 32'd1);
  endtask

  task automatic run_op(input int idx, input string tag,
                        input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                        input logic tmode, input logic [15:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf);
    int lat;
    a = ta; b = tb; cin = tcin; mode = tmode;
    set_start(idx, 1'b1);
    tick();
    set_start(idx, 1'b0);
    a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1; mode = ~tmode;
    check({tag, "_busy"}, {31'd0, get_busy(idx)}, 32'd1);
    lat = 0;
    wait_done(idx, tag, lat);
    check({tag, "_latency"}, lat, digits_of(idx));
    check({tag, "_sum"}, {16'd0, get_sum(idx)}, {16'd0, exp_sum});
    check({tag, "_cout"}, {31'd0, get_cout(idx)}, {31'd0, exp_cout});
    check({tag, "_ovf"}, {31'd0, get_ovf(idx)}, {31'd0, exp_ovf});
    check({tag, "_busy_at_done"}, {31'd0, get_busy(idx)}, 32'd0);
    tick();
    check({tag, "_done_pulse"}, {31'd0, get_done(idx)}, 32'd0);
  endtask

  initial begin
    int lat;
    // Reset with Start asserted: nothing may start, all outputs cleared.
    rst_n = 1'b0; mode = 1'b0; cin = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
    start4 = 1'b1; start1 = 1'b1; start16 = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      check("rst_sum", {16'd0, get_sum(i)}, 32'd0);
      check("rst_cout", {31'd0, get_cout(i)}, 32'd0);
      check("rst_ovf", {31'd0, get_ovf(i)}, 32'd0);
      check("rst_busy", {31'd0, get_busy(i)}, 32'd0);
      check("rst_done", {31'd0, get_done(i)}, 32'd0);
    end
    start4 = 1'b0; start1 = 1'b0; start16 = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", {31'd0, busy4}, 32'd0);

    // Directed arithmetic cases on every digit size.
    for (int i = 0; i < 3; i++) begin
      run_op(i, "add_chain",  16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
      run_op(i, "add_cout",   16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
      run_op(i, "add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_op(i, "sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_op(i, "sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    end

    // Start while busy is ignored.
    a = 16'h0001; b = 16'h0002; cin = 1'b0; mode = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    a = 16'hAAAA; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check("hs_partial_hidden", {16'd0, sum4}, 32'h7FFF);
    lat = 2;
    wait_done(0, "hs_ignore", lat);
    check("hs_ignore_latency", lat, 4);
    check("hs_ignore_sum", {16'd0, sum4}, 32'h0003);

    // Back-to-back: Start held in the Done cycle is accepted.
    a = 16'h1000; b = 16'h0234; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check("b2b_busy", {31'd0, busy4}, 32'd1);
    check("b2b_done_low", {31'd0, done4}, 32'd0);
    check("b2b_sum_held", {16'd0, sum4}, 32'h0003);
    lat = 0;
    wait_done(0, "b2b", lat);
    check("b2b_latency", lat, 4);
    check("b2b_sum", {16'd0, sum4}, 32'h1234);

    // Reset at the second RUN edge aborts the operation.
    tick();
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; mode = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_busy", {31'd0, busy4}, 32'd0);
    check("midrst_done", {31'd0, done4}, 32'd0);
    check("midrst_sum", {16'd0, sum4}, 32'd0);
    lat = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done4 === 1'b1) lat++;
    end
    check("midrst_no_done", lat, 0);
    run_op(0, "midrst_fresh", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
- Parametrised, clocked successor to the single-bit full adder. Adds or subtracts two WIDTH-bit operands DIGIT bits per cycle, with the carry held in a register between digits.
- Trades latency for area. Takes a Start/Busy/Done handshake and returns the registered result with carry-out and signed overflow.
- Used wherever a multi-bit add/subtract must share one narrow adder slice across cycles.

Parameters:
- WIDTH, 16, operand and result width in bits.
- DIGIT, 4, bits processed per cycle. WIDTH must be an integer multiple of DIGIT; otherwise elaboration fails.
- N (localparam), WIDTH/DIGIT, number of digit cycles.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  active-low reset, synchronous to Clk.
- Start  input  1  request; sampled only when Busy=0.
- Mode  input  1  0: A+B+Cin; 1: A-B-Cin (computed as A + ~B + ~Cin).
- A  input  WIDTH  operand A, captured on accepted Start.
- B  input  WIDTH  operand B, captured on accepted Start.
- Cin  input  1  carry/borrow in, captured on accepted Start.
- Sum  output  WIDTH  registered result; held until the next completion.
- Cout  output  1  final carry out (for subtract: 1 = no borrow).
- Overflow  output  1  signed two's-complement overflow of the final result.
- Busy  output  1  high while an operation is in progress.
- Done  output  1  one-cycle pulse when Sum/Cout/Overflow update.

Behaviour:
- Reset: Rst_n low at a rising edge forces IDLE. Sum=0, Cout=0, Overflow=0, Busy=0, Done=0. Digit counter, carry and operand registers are cleared. Reset has priority over all other inputs, including mid-operation.
- States: IDLE, RUN.
- IDLE:
  - Busy=0.
  - On an edge with Start=1: latch A into opA, B^{WIDTH{Mode}} into opB, and carry=Cin^Mode; clear the counter; go to RUN.
  - Start=0: stay in IDLE.
- RUN, one digit per edge, k = 0..N-1:
  - {c, s} = opA[DIGIT-1:0] + opB[DIGIT-1:0] + carry.
  - s is shifted into the result shift register from the MSB side; opA and opB shift right by DIGIT; carry <= c.
  - Busy=1 throughout RUN.
- Completion, at the edge processing digit N-1:
  - Sum <= assembled result; Cout <= final carry.
  - Overflow <= (carry into MSB) XOR (carry out of MSB), taken from the last digit's internal MSB carry.
  - Done=1 for the following cycle only; state returns to IDLE, so Busy=0 in that same cycle.
- Latency:
  - Start sampled at edge T0; Done, Busy=0 and new Sum are visible after edge TN, i.e. N cycles after acceptance.
  - Throughput is one operation per N+1 cycles when back-to-back.
- Start while Busy=1 is ignored. Operand inputs are don't-care while Busy=1.
- Start=1 in the Done cycle (state IDLE) is accepted: back-to-back operation, with Done for the second one N cycles later.
- Sum, Cout and Overflow change only at completion or reset. They never show partial results.
- Boundary configurations:
  - DIGIT=WIDTH: N=1, result after one cycle.
  - DIGIT=1: N=WIDTH, bit-serial.
  - The counter must wrap-free cover N.
- All arithmetic is unsigned modulo 2^WIDTH. Overflow reports the signed interpretation.

Test Plan (WIDTH=16, DIGIT=4, N=4 unless noted):
1. Reset: Rst_n=0 for 2 edges with Start=1 -> Sum=16'h0000, Cout=0, Overflow=0, Busy=0, Done=0; no operation starts.
2. Add with carry chain: A=16'h00FF, B=16'h0001, Cin=0, Mode=0 -> Busy high for 4 cycles; Done pulse 4 cycles after Start; Sum=16'h0100, Cout=0, Overflow=0.
3. Add carry/overflow:
   - A=16'hFFFF, B=16'h0001, Cin=1 -> Sum=16'h0001, Cout=1, Overflow=0.
   - Then A=16'h7FFF, B=16'h0001, Cin=0 -> Sum=16'h8000, Cout=0, Overflow=1.
4. Subtract:
   - A=16'h0005, B=16'h0007, Cin=0, Mode=1 -> Sum=16'hFFFE, Cout=0 (borrow), Overflow=0.
   - A=16'h8000, B=16'h0001, Mode=1 -> Sum=16'h7FFF, Cout=1, Overflow=1.
5. Handshake:
   - Start (A=1, B=2) accepted, then Start (A=16'hAAAA) pulsed while Busy -> ignored; Sum=16'h0003.
   - Start held high in the Done cycle with A=16'h1000, B=16'h0234 -> accepted; next Done 4 cycles later with Sum=16'h1234.
   - Repeat directed cases 2-4 with DIGIT=1 and DIGIT=16 -> identical results, latency 16 and 1 respectively.
6. Reset mid-operation: Rst_n=0 at the 2nd RUN edge -> Busy=0, no Done pulse, Sum=0. A fresh Start after release completes normally with the correct result.
